// File: rtl/tc_traffic_sensor.sv
// Traffic sensor for a two-street crossing: per-street car queues drained while green,
// with sticky overflow and illegal-lights error reporting.
module tc_traffic_sensor #(
    parameter int unsigned QW         = 4,
    parameter int unsigned DEPART_CYC = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ARR_A,
    input  logic          ARR_B,
    input  logic [2:0]    L_A,
    input  logic [2:0]    L_B,
    input  logic          CLR_ERR,
    output logic          T_A,
    output logic          T_B,
    output logic [QW-1:0] Q_A,
    output logic [QW-1:0] Q_B,
    output logic          OVF_A,
    output logic          OVF_B,
    output logic          ERR,
    output logic [1:0]    ERR_CODE
);

    localparam int unsigned TW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FLOW = 1'b1
    } state_t;

    logic [2:0]    lights [2];
    logic [1:0]    arr;
    logic [1:0]    legal;
    logic [1:0]    green;
    logic [1:0]    ovf;
    logic [QW-1:0] q [2];
    logic          conflict;
    logic          err_any;
    logic [1:0]    err_code_nxt;

    assign lights[0] = L_A;
    assign lights[1] = L_B;
    assign arr       = {ARR_B, ARR_A};

    assign conflict = legal[0] & legal[1] & ~L_A[0] & ~L_B[0];
    assign err_any  = ~legal[0] | ~legal[1] | conflict;

    // First-error cause, A illegal outranks B illegal outranks conflict
    always_comb begin
        err_code_nxt = 2'b11;
        if (!legal[0]) begin
            err_code_nxt = 2'b01;
        end else if (!legal[1]) begin
            err_code_nxt = 2'b10;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
        end else if (CLR_ERR) begin
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
        end else if (!ERR && err_any) begin
            ERR      <= 1'b1;
            ERR_CODE <= err_code_nxt;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_street
        state_t        state;
        state_t        state_nxt;
        logic [TW-1:0] timer;
        logic [TW-1:0] timer_nxt;
        logic          depart;
        logic [QW-1:0] cnt;
        logic          ovf_r;

        assign legal[i] = (lights[i] == 3'b001) || (lights[i] == 3'b010) ||
                          (lights[i] == 3'b100);
        assign green[i] = legal[i] & lights[i][2];

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                state <= state_nxt;
                timer <= timer_nxt;
            end
        end

        // Timer advances on every cycle the street flows, so the first car leaves
        // DEPART_CYC green cycles after the light turns
        always_comb begin
            state_nxt = state;
            timer_nxt = '0;
            depart    = 1'b0;
            case (state)
                IDLE:    if (green[i] && !conflict) state_nxt = FLOW;
                FLOW:    if (!green[i] || conflict) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            if (state_nxt == FLOW) begin
                if (timer == TW'(DEPART_CYC - 1)) begin
                    depart = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
        end

        // Arrival and departure in one cycle cancel, even at full
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                cnt   <= '0;
                ovf_r <= 1'b0;
            end else begin
                if (arr[i] && !depart) begin
                    if (cnt == {QW{1'b1}}) begin
                        ovf_r <= 1'b1;
                    end else begin
                        cnt <= cnt + QW'(1);
                    end
                end else if (depart && !arr[i] && (cnt != '0)) begin
                    cnt <= cnt - QW'(1);
                end
                if (CLR_ERR) begin
                    ovf_r <= 1'b0;
                end
            end
        end

        assign q[i]   = cnt;
        assign ovf[i] = ovf_r;
    end

    assign Q_A   = q[0];
    assign Q_B   = q[1];
    assign OVF_A = ovf[0];
    assign OVF_B = ovf[1];
    assign T_A   = (Q_A != '0);
    assign T_B   = (Q_B != '0);

endmodule
